dm_sba_apb_bridge: RTL and testbench
====================================

Name: dm_sba_apb_bridge

Overview:
Downstream of the SBA control/register pair. Converts the SBA master request/grant/response interface into a single APB3/APB4 requester port on the system interconnect. Exactly one transfer is outstanding at a time. An access-phase timeout counter reports hung slaves as "other error" so that sbcs.sberror can be set instead of the debug module deadlocking.

Parameters:
- ADDR_W, 32: APB address width; master_add_i is truncated or zero-extended to this width.
- TIMEOUT_CYCLES, 256: access-phase cycles before the transfer is abandoned; 0 disables the timeout.
- PPROT, 3'b010: constant pprot_o value (non-secure, data, unprivileged).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- dmactive_i  in  1  debug module active; low means the current response is discarded
- master_req_i  in  1  SBA request
- master_add_i  in  32  byte address
- master_we_i  in  1  1 = write
- master_wdata_i  in  32  write data
- master_be_i  in  4  byte enables
- master_gnt_o  out  1  request accepted
- master_r_valid_o  out  1  response pulse (read or write)
- master_r_err_o  out  1  slave error (pslverr), qualified by r_valid
- master_r_other_err_o  out  1  timeout error, qualified by r_valid
- master_r_rdata_o  out  32  read data, qualified by r_valid
- paddr_o  out  ADDR_W  APB address, word-aligned
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- pwrite_o  out  1  APB write
- pwdata_o  out  32  APB write data
- pstrb_o  out  4  APB strobes (be for writes, 0 for reads)
- pprot_o  out  3  constant PPROT
- prdata_i  in  32  APB read data
- pready_i  in  1  APB ready
- pslverr_i  in  1  APB slave error

Behaviour:
- Reset values: all outputs 0, except pprot_o = PPROT. State is IDLE and the timeout counter is 0.
- FSM states:
  - IDLE: master_gnt_o = master_req_i (combinational). On req, capture addr/we/wdata/be into holding registers and go to SETUP.
  - SETUP: psel = 1, penable = 0, one cycle; then go to ACCESS.
  - ACCESS: psel = 1, penable = 1. The counter increments each cycle pready = 0.
    - On pready = 1: capture prdata (reads only, else 0) and pslverr, then go to RESP.
    - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1 with pready = 0: deassert psel/penable next cycle, set other_err, go to RESP.
  - RESP: master_r_valid_o = 1 for exactly one cycle together with r_err/r_other_err/rdata; then go to IDLE.
- APB outputs come from the holding registers and are stable from SETUP through ACCESS.
  - paddr_o = {addr[ADDR_W-1:2], 2'b00}.
  - pstrb_o = we ? be : 4'b0.
- Latency: gnt in cycle 0, SETUP in cycle 1, ACCESS in cycle 2. With zero wait states, r_valid is in cycle 3. Each wait state adds one cycle.
- Grant is never asserted outside IDLE. There is no back-to-back acceptance, so the minimum spacing between grants is 4 cycles.
- r_err and r_other_err are mutually exclusive. A timeout forces r_err = 0 and rdata = 0.
- dmactive_i low mid-transfer: the APB transfer still completes per protocol, with no early psel drop except on timeout. The RESP cycle is entered but r_valid is suppressed (all response outputs 0). In IDLE, no grant is given while dmactive_i = 0.
- pready = 1 on the timeout-boundary cycle: this counts as normal completion and timeout is not flagged.
- Asynchronous reset mid-transfer: psel/penable drop immediately and the FSM returns to IDLE. The interconnect must be reset with it.
- master_req_i held high through a response: it is re-granted on the first IDLE cycle after RESP.
- The counter saturates and clears on entry to SETUP.

Decomposition:
- dm package: add the state enum sba_apb_state_e {IDLE, SETUP, ACCESS, RESP} and the constant default PPROT.
- Sub-module dm_sba_timeout_cnt: clear, enable, and limit parameter; outputs expired.
- Everything else stays in one module.

Test Plan:
- Zero-wait read of 0x0000_1004 with prdata 0xDEADBEEF: gnt at cycle 0, psel at cycles 1-2, penable at cycle 2, r_valid at cycle 3 with rdata = 0xDEADBEEF and both err = 0; paddr = 0x1004, pstrb = 0.
- Write of 0x0000_2002 with be = 4'b1100, wdata 0x12345678, and 3 wait states: paddr = 0x2000, pstrb = 4'b1100, pwrite = 1, signals stable throughout ACCESS; r_valid at cycle 6.
- Read completing with pslverr = 1: r_valid with r_err = 1, r_other_err = 0.
- TIMEOUT_CYCLES = 8 with pready stuck at 0: psel drops after 8 ACCESS cycles; r_valid with r_other_err = 1, rdata = 0. A following request is granted normally.
- dmactive_i dropped during ACCESS, then pready after 2 cycles: the APB transfer completes, no r_valid, and no grant while dmactive_i = 0.
- Back-to-back reads with req held high: second gnt exactly one cycle after the first r_valid; rst_ni pulsed mid-ACCESS clears psel/penable asynchronously.

Source files
------------

// File: rtl/dm_sba_apb_bridge_pkg.sv
// Shared types and constants for the SBA-to-APB bridge.
package dm_sba_apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } sba_apb_state_e;

  // Non-secure, data, unprivileged.
  localparam logic [2:0] PPROT_DEFAULT = 3'b010;

endpackage

// File: rtl/dm_sba_apb_bridge_if.sv
// SBA request/response channel plus APB requester signals.
// slave modport: the bridge (serves SBA requests, drives APB).
// master modport: the surrounding system (issues SBA requests, answers APB).
interface dm_sba_apb_bridge_if #(
  parameter int unsigned ADDR_W = 32
);

  logic              master_req_i;
  logic [31:0]       master_add_i;
  logic              master_we_i;
  logic [31:0]       master_wdata_i;
  logic [3:0]        master_be_i;
  logic              master_gnt_o;
  logic              master_r_valid_o;
  logic              master_r_err_o;
  logic              master_r_other_err_o;
  logic [31:0]       master_r_rdata_o;

  logic [ADDR_W-1:0] paddr_o;
  logic              psel_o;
  logic              penable_o;
  logic              pwrite_o;
  logic [31:0]       pwdata_o;
  logic [3:0]        pstrb_o;
  logic [2:0]        pprot_o;
  logic [31:0]       prdata_i;
  logic              pready_i;
  logic              pslverr_i;

  modport slave (
    input  master_req_i, master_add_i, master_we_i, master_wdata_i, master_be_i,
    output master_gnt_o, master_r_valid_o, master_r_err_o, master_r_other_err_o,
    output master_r_rdata_o,
    output paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o, pprot_o,
    input  prdata_i, pready_i, pslverr_i
  );

  modport master (
    output master_req_i, master_add_i, master_we_i, master_wdata_i, master_be_i,
    input  master_gnt_o, master_r_valid_o, master_r_err_o, master_r_other_err_o,
    input  master_r_rdata_o,
    input  paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o, pprot_o,
    output prdata_i, pready_i, pslverr_i
  );

endinterface

// File: rtl/dm_sba_timeout_cnt.sv
// Access-phase wait counter. Ports: clear_i zeroes the count, en_i advances
// it (saturating), expired_o flags count == LIMIT-1. LIMIT = 0 never expires.
module dm_sba_timeout_cnt #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned   CW   = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = (LIMIT == 0) ? '0 : CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (LIMIT != 0) && (cnt_q == LAST);

endmodule

// File: rtl/dm_sba_apb_bridge.sv
// SBA master port to single APB requester, one transfer outstanding.
// Ports: clk_i, rst_ni (async, active low), dmactive_i (low discards the
// response and blocks grants), bus (SBA request/response + APB signals).
module dm_sba_apb_bridge
  import dm_sba_apb_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [2:0]  PPROT          = PPROT_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               dmactive_i,
  dm_sba_apb_bridge_if.slave bus
);

  sba_apb_state_e    state_q, state_d;
  logic [ADDR_W-3:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              oerr_q, oerr_d;
  logic              discard_q, discard_d;

  logic              gnt;
  logic              expired;
  logic              r_valid;
  logic [ADDR_W-3:0] word_add;

  // Word address only; low byte-offset bits never reach APB.
  assign word_add = (ADDR_W-2)'(bus.master_add_i >> 2);

  dm_sba_timeout_cnt #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (gnt),
    .en_i     ((state_q == ACCESS) && !bus.pready_i),
    .expired_o(expired)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    oerr_d    = oerr_q;
    discard_d = discard_q;
    gnt       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.master_req_i && dmactive_i) begin
          gnt       = 1'b1;
          addr_d    = word_add;
          we_d      = bus.master_we_i;
          wdata_d   = bus.master_wdata_i;
          be_d      = bus.master_be_i;
          discard_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // Ready wins over an expiry in the same cycle.
        if (bus.pready_i) begin
          rdata_d = we_q ? '0 : bus.prdata_i;
          err_d   = bus.pslverr_i;
          oerr_d  = 1'b0;
          state_d = RESP;
        end else if (expired) begin
          rdata_d = '0;
          err_d   = 1'b0;
          oerr_d  = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Any dmactive drop during a transfer discards its response.
    if ((state_q != IDLE) && !dmactive_i) begin
      discard_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      be_q      <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      oerr_q    <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      oerr_q    <= oerr_d;
      discard_q <= discard_d;
    end
  end

  assign r_valid = (state_q == RESP) && !discard_q && dmactive_i;

  assign bus.master_gnt_o         = gnt;
  assign bus.master_r_valid_o     = r_valid;
  assign bus.master_r_err_o       = r_valid && err_q;
  assign bus.master_r_other_err_o = r_valid && oerr_q;
  assign bus.master_r_rdata_o     = r_valid ? rdata_q : '0;

  assign bus.psel_o    = (state_q == SETUP) || (state_q == ACCESS);
  assign bus.penable_o = (state_q == ACCESS);
  assign bus.paddr_o   = {addr_q, 2'b00};
  assign bus.pwrite_o  = we_q;
  assign bus.pwdata_o  = wdata_q;
  assign bus.pstrb_o   = we_q ? be_q : '0;
  assign bus.pprot_o   = PPROT;

endmodule

// File: tb/tb_dm_sba_apb_bridge.sv
module tb_dm_sba_apb_bridge;

  localparam int TO = 8;

  logic clk_i      = 1'b0;
  logic rst_ni     = 1'b0;
  logic dmactive_i = 1'b0;

  dm_sba_apb_bridge_if #(.ADDR_W(32)) bus ();

  dm_sba_apb_bridge #(
    .ADDR_W        (32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .dmactive_i(dmactive_i),
    .bus       (bus)
  );

  always #5 clk_i = ~clk_i;

  // APB slave: inserts cfg_waits wait states, then answers.
  int          cfg_waits  = 0;
  logic [31:0] cfg_prdata = '0;
  logic        cfg_slverr = 1'b0;
  int          wcnt       = 0;

  always @(posedge clk_i)
    wcnt <= (bus.psel_o && bus.penable_o && !bus.pready_i) ? wcnt + 1 : 0;

  assign bus.pready_i  = bus.psel_o && bus.penable_o && (wcnt == cfg_waits);
  assign bus.prdata_i  = cfg_prdata;
  assign bus.pslverr_i = cfg_slverr && bus.pready_i;

  int total = 0;
  int bad   = 0;

  logic        ob_gnt0, ob_pwrite, ob_err, ob_oerr, ob_stable, ob_resp_any;
  int          ob_gnt_late, ob_psel_n, ob_psel_first, ob_pen_n, ob_pen_first, ob_rv_n, ob_rv_cyc;
  logic [31:0] ob_paddr, ob_pwdata, ob_rdata;
  logic [3:0]  ob_pstrb;

  // Runs one SBA transfer (cycle 0 = request cycle) and records what was seen.
  task automatic do_xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                         input logic [3:0] be, input int waits, input logic [31:0] rd,
                         input logic se, input int drop_at);
    int n;
    n = ((waits < TO) ? waits : TO) + 6;
    cfg_waits = waits; cfg_prdata = rd; cfg_slverr = se;
    ob_gnt0 = 0; ob_gnt_late = 0; ob_psel_n = 0; ob_psel_first = -1; ob_pen_n = 0;
    ob_pen_first = -1; ob_rv_n = 0; ob_rv_cyc = -1; ob_stable = 1; ob_resp_any = 0;
    ob_rdata = '0; ob_err = 0; ob_oerr = 0;
    @(posedge clk_i); #1;
    bus.master_req_i = 1'b1; bus.master_add_i = a; bus.master_we_i = w;
    bus.master_wdata_i = wd; bus.master_be_i = be;
    for (int c = 0; c <= n; c++) begin
      if (c > 0) begin
        @(posedge clk_i); #1;
        bus.master_req_i = 1'b0;
      end
      if (drop_at >= 0 && c >= drop_at) dmactive_i = 1'b0;
      @(negedge clk_i);
      if (c == 0) ob_gnt0 = bus.master_gnt_o;
      else if (bus.master_gnt_o) ob_gnt_late++;
      if (bus.psel_o) begin
        ob_psel_n++;
        if (ob_psel_first < 0) begin
          ob_psel_first = c; ob_paddr = bus.paddr_o; ob_pwrite = bus.pwrite_o;
          ob_pwdata = bus.pwdata_o; ob_pstrb = bus.pstrb_o;
        end else if (ob_paddr !== bus.paddr_o || ob_pwrite !== bus.pwrite_o ||
                     ob_pwdata !== bus.pwdata_o || ob_pstrb !== bus.pstrb_o) begin
          ob_stable = 0;
        end
      end
      if (bus.penable_o) begin
        ob_pen_n++;
        if (ob_pen_first < 0) ob_pen_first = c;
      end
      if (bus.master_r_valid_o) begin
        ob_rv_n++; ob_rv_cyc = c; ob_rdata = bus.master_r_rdata_o;
        ob_err = bus.master_r_err_o; ob_oerr = bus.master_r_other_err_o;
      end
      if (bus.master_r_valid_o || bus.master_r_err_o || bus.master_r_other_err_o ||
          (|bus.master_r_rdata_o)) ob_resp_any = 1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] acc;
    #22;
    acc = bus.paddr_o | bus.pwdata_o | bus.master_r_rdata_o |
          {24'd0, bus.pstrb_o, bus.psel_o, bus.penable_o, bus.pwrite_o,
           bus.master_gnt_o, bus.master_r_valid_o, bus.master_r_err_o,
           bus.master_r_other_err_o, 1'b0};
    total++; if (acc !== 32'd0) begin bad++; $display("FAIL reset_outputs: got %h expected 0", acc); end
    total++; if (bus.pprot_o !== 3'b010) begin bad++; $display("FAIL reset_pprot: got %b expected 010", bus.pprot_o); end
    @(posedge clk_i); #1;
    rst_ni = 1'b1; dmactive_i = 1'b1;
  endtask

  task automatic test_zero_wait_read();
    do_xfer(32'h0000_1004, 1'b0, 32'h0, 4'hF, 0, 32'hDEADBEEF, 1'b0, -1);
    total++; if (ob_gnt0 !== 1'b1) begin bad++; $display("FAIL zw_gnt: got %b expected 1", ob_gnt0); end
    total++; if (ob_psel_first != 1 || ob_psel_n != 2) begin bad++; $display("FAIL zw_psel: got first=%0d n=%0d expected 1,2", ob_psel_first, ob_psel_n); end
    total++; if (ob_pen_first != 2 || ob_pen_n != 1) begin bad++; $display("FAIL zw_penable: got first=%0d n=%0d expected 2,1", ob_pen_first, ob_pen_n); end
    total++; if (ob_rv_cyc != 3 || ob_rv_n != 1) begin bad++; $display("FAIL zw_rvalid: got cyc=%0d n=%0d expected 3,1", ob_rv_cyc, ob_rv_n); end
    total++; if (ob_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL zw_rdata: got %h expected deadbeef", ob_rdata); end
    total++; if ({ob_err, ob_oerr} !== 2'b00) begin bad++; $display("FAIL zw_err: got %b expected 00", {ob_err, ob_oerr}); end
    total++; if (ob_paddr !== 32'h1004 || ob_pstrb !== 4'h0 || ob_pwrite !== 1'b0) begin bad++; $display("FAIL zw_apb: got addr=%h strb=%b we=%b expected 1004,0000,0", ob_paddr, ob_pstrb, ob_pwrite); end
    total++; if (ob_gnt_late != 0) begin bad++; $display("FAIL zw_gnt_late: got %0d expected 0", ob_gnt_late); end
  endtask

  task automatic test_write_wait();
    do_xfer(32'h0000_2002, 1'b1, 32'h12345678, 4'b1100, 3, 32'hFFFF_FFFF, 1'b0, -1);
    total++; if (ob_paddr !== 32'h2000 || ob_pstrb !== 4'b1100 || ob_pwrite !== 1'b1 || ob_pwdata !== 32'h12345678) begin bad++; $display("FAIL wr_apb: got addr=%h strb=%b we=%b wd=%h", ob_paddr, ob_pstrb, ob_pwrite, ob_pwdata); end
    total++; if (ob_stable !== 1'b1) begin bad++; $display("FAIL wr_stable: got %b expected 1", ob_stable); end
    total++; if (ob_rv_cyc != 6 || ob_pen_n != 4) begin bad++; $display("FAIL wr_timing: got rv=%0d pen=%0d expected 6,4", ob_rv_cyc, ob_pen_n); end
    total++; if (ob_rdata !== 32'h0 || ob_err !== 1'b0) begin bad++; $display("FAIL wr_resp: got rdata=%h err=%b expected 0,0", ob_rdata, ob_err); end
  endtask

  task automatic test_slverr();
    do_xfer(32'h0000_3008, 1'b0, 32'h0, 4'hF, 1, 32'h0000_0055, 1'b1, -1);
    total++; if ({ob_err, ob_oerr} !== 2'b10) begin bad++; $display("FAIL se_err: got %b expected 10", {ob_err, ob_oerr}); end
    total++; if (ob_rv_cyc != 4 || ob_rdata !== 32'h55) begin bad++; $display("FAIL se_resp: got rv=%0d rdata=%h expected 4,55", ob_rv_cyc, ob_rdata); end
  endtask

  task automatic test_timeout();
    do_xfer(32'h0000_4000, 1'b0, 32'h0, 4'hF, 1000, 32'hFFFF_FFFF, 1'b1, -1);
    total++; if (ob_psel_n != TO + 1 || ob_pen_n != TO) begin bad++; $display("FAIL to_psel: got psel=%0d pen=%0d expected %0d,%0d", ob_psel_n, ob_pen_n, TO + 1, TO); end
    total++; if (ob_rv_cyc != TO + 2) begin bad++; $display("FAIL to_rvalid: got %0d expected %0d", ob_rv_cyc, TO + 2); end
    total++; if ({ob_err, ob_oerr} !== 2'b01 || ob_rdata !== 32'h0) begin bad++; $display("FAIL to_resp: got err=%b rdata=%h expected 01,0", {ob_err, ob_oerr}, ob_rdata); end
    // Ready on the last allowed cycle is a normal completion.
    do_xfer(32'h0000_4004, 1'b0, 32'h0, 4'hF, TO - 1, 32'hA5A5_0001, 1'b0, -1);
    total++; if (ob_gnt0 !== 1'b1) begin bad++; $display("FAIL to_regrant: got %b expected 1", ob_gnt0); end
    total++; if (ob_rv_cyc != TO + 2 || ob_oerr !== 1'b0 || ob_rdata !== 32'hA5A5_0001) begin bad++; $display("FAIL to_boundary: got rv=%0d oerr=%b rdata=%h", ob_rv_cyc, ob_oerr, ob_rdata); end
  endtask

  task automatic test_dmactive();
    int g;
    do_xfer(32'h0000_5000, 1'b0, 32'h0, 4'hF, 2, 32'h1111_2222, 1'b0, 2);
    total++; if (ob_pen_n != 3 || ob_psel_n != 4) begin bad++; $display("FAIL dm_apb: got pen=%0d psel=%0d expected 3,4", ob_pen_n, ob_psel_n); end
    total++; if (ob_rv_n != 0 || ob_resp_any !== 1'b0) begin bad++; $display("FAIL dm_resp: got rv=%0d any=%b expected 0,0", ob_rv_n, ob_resp_any); end
    g = 0;
    bus.master_req_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      if (bus.master_gnt_o) g++;
      @(posedge clk_i); #1;
    end
    bus.master_req_i = 1'b0;
    dmactive_i = 1'b1;
    total++; if (g != 0) begin bad++; $display("FAIL dm_nogrant: got %0d grants expected 0", g); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] gm, rm;
    gm = '0; rm = '0;
    cfg_waits = 0; cfg_prdata = 32'hCAFE_0001; cfg_slverr = 1'b0;
    @(posedge clk_i); #1;
    bus.master_req_i = 1'b1; bus.master_add_i = 32'h40; bus.master_we_i = 1'b0; bus.master_be_i = 4'hF;
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) begin @(posedge clk_i); #1; end
      if (c == 9) begin bus.master_req_i = 1'b0; cfg_waits = 1000; end
      @(negedge clk_i);
      gm[c] = bus.master_gnt_o; rm[c] = bus.master_r_valid_o;
    end
    total++; if (gm !== 16'h0111) begin bad++; $display("FAIL b2b_gnt: got %h expected 0111", gm); end
    total++; if (rm !== 16'h0088) begin bad++; $display("FAIL b2b_rvalid: got %h expected 0088", rm); end
    total++; if ({bus.psel_o, bus.penable_o} !== 2'b11) begin bad++; $display("FAIL b2b_access: got %b expected 11", {bus.psel_o, bus.penable_o}); end
    #2 rst_ni = 1'b0;
    #1;
    total++; if ({bus.psel_o, bus.penable_o} !== 2'b00) begin bad++; $display("FAIL async_rst: got %b expected 00", {bus.psel_o, bus.penable_o}); end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    do_xfer(32'h0000_0044, 1'b0, 32'h0, 4'hF, 0, 32'h0BAD_F00D, 1'b0, -1);
    total++; if (ob_gnt0 !== 1'b1 || ob_rv_cyc != 3 || ob_rdata !== 32'h0BAD_F00D) begin bad++; $display("FAIL post_rst: got gnt=%b rv=%0d rdata=%h", ob_gnt0, ob_rv_cyc, ob_rdata); end
  endtask

  task automatic test_random();
    logic [31:0] a, wd, rd, e_rdata;
    logic [3:0]  be;
    logic        w, se, tmo;
    int          waits, e_rv, e_pen;
    for (int i = 0; i < 24; i++) begin
      a = $urandom; wd = $urandom; rd = $urandom; be = 4'($urandom);
      w = 1'($urandom); se = 1'($urandom); waits = int'($urandom_range(0, 10));
      do_xfer(a, w, wd, be, waits, rd, se, -1);
      tmo     = (waits >= TO);
      e_rv    = tmo ? TO + 2 : waits + 3;
      e_pen   = tmo ? TO : waits + 1;
      e_rdata = (tmo || w) ? 32'h0 : rd;
      total++; if (ob_gnt0 !== 1'b1 || ob_rv_cyc != e_rv || ob_pen_n != e_pen) begin bad++; $display("FAIL rnd_timing[%0d]: got gnt=%b rv=%0d pen=%0d expected 1,%0d,%0d", i, ob_gnt0, ob_rv_cyc, ob_pen_n, e_rv, e_pen); end
      total++; if (ob_rdata !== e_rdata || ob_err !== (se && !tmo) || ob_oerr !== tmo) begin bad++; $display("FAIL rnd_resp[%0d]: got %h/%b/%b expected %h/%b/%b", i, ob_rdata, ob_err, ob_oerr, e_rdata, se && !tmo, tmo); end
      total++; if (ob_paddr !== {a[31:2], 2'b00} || ob_pstrb !== (w ? be : 4'h0) || ob_pwrite !== w || ob_stable !== 1'b1) begin bad++; $display("FAIL rnd_apb[%0d]: got addr=%h strb=%b we=%b stable=%b", i, ob_paddr, ob_pstrb, ob_pwrite, ob_stable); end
      if (w) begin
        total++; if (ob_pwdata !== wd) begin bad++; $display("FAIL rnd_pwdata[%0d]: got %h expected %h", i, ob_pwdata, wd); end
      end
    end
  endtask

  initial begin
    bus.master_req_i = 1'b0; bus.master_add_i = '0; bus.master_we_i = 1'b0;
    bus.master_wdata_i = '0; bus.master_be_i = '0;
    test_reset();
    test_zero_wait_read();
    test_write_wait();
    test_slverr();
    test_timeout();
    test_dmactive();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
